// File: rtl/tdm_demux.sv
// tdm_demux: routes tagged 2-bit symbols to four per-channel packers; every
// four symbols on a channel become one byte, presented LSB-first on that
// channel's own valid/ready output.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   flush           synchronous clear of all partial accumulators
//   in_valid/ready  input handshake (in_ready is combinational)
//   in_sel, in_data destination channel and 2-bit symbol
//   out_valid[k]    channel k byte valid
//   out_ready[k]    channel k consumer takes its byte
//   out_data        channel k byte on bits [8k+7:8k]
module tdm_demux (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_sel,
    input  logic [1:0]  in_data,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready,
    output logic [31:0] out_data
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned SYM_W = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned ACC_W = 6;
    localparam int unsigned BYTE_W = 8;

    logic [CNT_W-1:0]  cnt  [NCH];
    logic [ACC_W-1:0]  acc  [NCH];
    logic [BYTE_W-1:0] obuf [NCH];
    logic [NCH-1:0]    ov;
    logic              accept;

    // Stall only when the symbol would complete a byte into a full, non-draining buffer.
    always_comb begin
        in_ready = !flush && !((cnt[in_sel] == CNT_W'(3)) && ov[in_sel] && !out_ready[in_sel]);
    end

    assign accept = in_valid && in_ready;

    // Per-channel accumulate, pack and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                cnt[k]  <= '0;
                acc[k]  <= '0;
                obuf[k] <= '0;
            end
            ov <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (flush) begin
                    cnt[k] <= '0;
                end
                if (accept && (in_sel == CNT_W'(k))) begin
                    if (cnt[k] == CNT_W'(3)) begin
                        // Load wins over a same-cycle drain: no bubble.
                        obuf[k] <= {in_data, acc[k]};
                        ov[k]   <= 1'b1;
                        cnt[k]  <= '0;
                    end else begin
                        case (cnt[k])
                            CNT_W'(0): acc[k][1:0] <= in_data;
                            CNT_W'(1): acc[k][3:2] <= in_data;
                            default:   acc[k][5:4] <= in_data;
                        endcase
                        cnt[k] <= cnt[k] + CNT_W'(1);
                        if (ov[k] && out_ready[k]) begin
                            ov[k] <= 1'b0;
                        end
                    end
                end else if (ov[k] && out_ready[k]) begin
                    ov[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = ov;

    // Flatten per-channel byte registers onto the output bus.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NCH; k++) begin
            out_data[BYTE_W*k +: BYTE_W] = obuf[k];
        end
    end

    // Symbol width is fixed; keep the parameter referenced for readers.
    logic unused_sym_w;
    assign unused_sym_w = (SYM_W == 2);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed testbench for tdm_demux: one task per scenario, inline checks.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [1:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;

    int total = 0;
    int bad   = 0;

    tdm_demux dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_sel = 2'd0; in_data = 2'd0; out_ready = 4'b0000;
        #2;
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000); end
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", out_data, 32'h0); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pack();
        send(2'd2, 2'b01);
        send(2'd2, 2'b10);
        send(2'd2, 2'b11);
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL pack_early got=%b exp=%b", out_valid, 4'b0000); end
        send(2'd2, 2'b00);
        total++;
        if (out_valid !== 4'b0100) begin bad++; $display("FAIL pack_valid got=%b exp=%b", out_valid, 4'b0100); end
        total++;
        if (out_data !== 32'h0039_0000) begin bad++; $display("FAIL pack_data got=%h exp=%h", out_data, 32'h0039_0000); end
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL pack_drain got=%b exp=%b", out_valid, 4'b0000); end
    endtask

    task automatic test_stall();
        out_ready = 4'b0000;
        repeat (4) send(2'd0, 2'b11);
        total++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'hFF) begin
            bad++; $display("FAIL stall_first got=%b/%h exp=0001/ff", out_valid, out_data[7:0]);
        end
        send(2'd0, 2'b00);
        send(2'd0, 2'b01);
        send(2'd0, 2'b10);
        total++;
        if (out_data[7:0] !== 8'hFF) begin bad++; $display("FAIL stall_hold got=%h exp=ff", out_data[7:0]); end
        in_valid = 1'b1; in_sel = 2'd0; in_data = 2'b11;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_block got=%b exp=0", in_ready); end
        in_sel = 2'd1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_other got=%b exp=1", in_ready); end
        in_sel = 2'd0; out_ready = 4'b0001;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_drain_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 4'b0001 || out_data[7:0] !== 8'hE4) begin
            bad++; $display("FAIL stall_reload got=%b/%h exp=0001/e4", out_valid, out_data[7:0]);
        end
        step();
        out_ready = 4'b0000;
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL stall_empty got=%b exp=0000", out_valid); end
    endtask

    task automatic test_interleave();
        logic [3:0] exp_v;
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 0) ? 2'd0 : 2'd1, (i % 2 == 0) ? 2'b11 : 2'b01);
            exp_v = (i == 6) ? 4'b0001 : (i == 7) ? 4'b0010 : 4'b0000;
            total++;
            if (out_valid !== exp_v) begin bad++; $display("FAIL ilv_valid[%0d] got=%b exp=%b", i, out_valid, exp_v); end
            if (i == 6) begin
                total++;
                if (out_data[7:0] !== 8'hFF) begin bad++; $display("FAIL ilv_ch0 got=%h exp=ff", out_data[7:0]); end
            end
            if (i == 7) begin
                total++;
                if (out_data[15:8] !== 8'h55) begin bad++; $display("FAIL ilv_ch1 got=%h exp=55", out_data[15:8]); end
            end
        end
        step();
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL ilv_tail got=%b exp=0000", out_valid); end
        out_ready = 4'b0000;
    endtask

    task automatic test_flush();
        send(2'd3, 2'b11);
        send(2'd3, 2'b11);
        flush = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_data = 2'b11;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        send(2'd3, 2'b00);
        send(2'd3, 2'b00);
        send(2'd3, 2'b00);
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL flush_early got=%b exp=0000", out_valid); end
        send(2'd3, 2'b10);
        total++;
        if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h80) begin
            bad++; $display("FAIL flush_byte got=%b/%h exp=1000/80", out_valid, out_data[31:24]);
        end
        out_ready = 4'b1000;
        step();
        out_ready = 4'b0000;
    endtask

    task automatic test_async_reset();
        repeat (4) send(2'd1, 2'b01);
        send(2'd1, 2'b10);
        send(2'd1, 2'b10);
        total++;
        if (out_valid !== 4'b0010) begin bad++; $display("FAIL ares_pending got=%b exp=0010", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
            bad++; $display("FAIL ares_immediate got=%b/%h exp=0000/0", out_valid, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        send(2'd1, 2'b10);
        send(2'd1, 2'b01);
        send(2'd1, 2'b00);
        send(2'd1, 2'b11);
        total++;
        if (out_valid !== 4'b0010 || out_data !== 32'h0000_C600) begin
            bad++; $display("FAIL ares_fresh got=%b/%h exp=0010/0000c600", out_valid, out_data);
        end
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [1:0] d [16];
        logic [7:0] exp_b;
        int         drops = 0;
        for (int i = 0; i < 16; i++) d[i] = 2'((i * 3) + (i / 4));
        out_ready = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sel = 2'd1; in_data = d[i];
            #1;
            if (in_ready !== 1'b1) drops++;
            step();
            total++;
            if (out_valid[1] !== (i % 4 == 3)) begin
                bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, out_valid[1], (i % 4 == 3));
            end
            if (i % 4 == 3) begin
                exp_b = {d[i], d[i-1], d[i-2], d[i-3]};
                total++;
                if (out_data[15:8] !== exp_b) begin bad++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i / 4, out_data[15:8], exp_b); end
            end
        end
        in_valid = 1'b0;
        total++;
        if (drops !== 0) begin bad++; $display("FAIL b2b_ready_drops got=%0d exp=0", drops); end
        step();
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL b2b_tail got=%b exp=0000", out_valid); end
        out_ready = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_stall();
        test_interleave();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
